// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command/response
// bytes and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    // Device-clocked slot indices after the start bit: 0..7 data, 8 parity, 9 stop.
    localparam logic [3:0] PS2_PARITY_IDX   = 4'd8;
    localparam logic [3:0] PS2_STOP_IDX     = 4'd9;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronizer for one raw PS/2 pin plus falling-edge detect on the
// synchronized level. Used for both ps2_clk and ps2_data.
module ps2_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic i_pin,
    output logic o_level,
    output logic o_fe
);

    logic [2:0] r_sync;
    logic       r_prev;

    // Reset to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync <= 3'b111;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[1:0], i_pin};
            r_prev <= r_sync[2];
        end
    end

    assign o_level = r_sync[2];
    assign o_fe    = r_prev & ~r_sync[2];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd
// parity, stop, then the device acknowledge, with an inter-edge timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a command byte, both pins released
// INHIBIT   | hold ps2_clk low; start bit driven in the final cycle
// RTS       | release clock, keep data low (start bit), clear bit count
// SEND      | update data on each device falling edge: D0..D7, parity, stop
// ACK       | sample the device acknowledge on the next falling edge
// WAIT_IDLE | wait for both lines high, then report done
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e       r_state;
    ps2_state_e       w_state_nxt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [3:0]       r_bit_cnt;
    logic             r_data_oe;
    logic             r_ack_ok;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_done;
    logic             r_err;

    logic w_clk_lvl;
    logic w_clk_fe;
    logic w_data_lvl;
    logic w_data_fe_unused;
    logic w_inh_last;
    logic w_to_active;
    logic w_to_expire;
    logic w_done_nxt;
    logic w_err_nxt;

    ps2_sync_edge u_sync_clk (
        .clk     (clk),
        .resetn  (resetn),
        .i_pin   (ps2_clk_i),
        .o_level (w_clk_lvl),
        .o_fe    (w_clk_fe)
    );

    ps2_sync_edge u_sync_data (
        .clk     (clk),
        .resetn  (resetn),
        .i_pin   (ps2_data_i),
        .o_level (w_data_lvl),
        .o_fe    (w_data_fe_unused)
    );

    assign w_inh_last  = (r_state == INHIBIT) && (r_inh_cnt == '0);
    assign w_to_active = (r_state == RTS) || (r_state == SEND) ||
                         (r_state == ACK) || (r_state == WAIT_IDLE);
    // A device edge landing on the expiry cycle keeps the transfer alive.
    assign w_to_expire = w_to_active && (r_to_cnt == '0) && !w_clk_fe;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                if (w_inh_last) begin
                    w_state_nxt = RTS;
                end
            end
            RTS: begin
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_clk_fe && (r_bit_cnt == PS2_STOP_IDX)) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                if (w_clk_fe) begin
                    w_state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_lvl && w_data_lvl) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = ~r_ack_ok;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_to_expire && (w_state_nxt != IDLE)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_data_oe <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_inh_cnt <= '0;
            r_to_cnt  <= TO_LOAD;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;

            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_shift   <= tx_data;
                        r_parity  <= odd_parity(tx_data);
                        r_inh_cnt <= INH_LOAD;
                    end
                end
                INHIBIT: begin
                    if (!w_inh_last) begin
                        r_inh_cnt <= r_inh_cnt - 1'b1;
                    end
                end
                RTS: begin
                    r_bit_cnt <= '0;
                    r_data_oe <= 1'b1;
                end
                SEND: begin
                    if (w_clk_fe) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt < PS2_PARITY_IDX) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end else if (r_bit_cnt == PS2_PARITY_IDX) begin
                            r_data_oe <= ~r_parity;
                        end else begin
                            r_data_oe <= 1'b0;
                        end
                    end
                end
                ACK: begin
                    if (w_clk_fe) begin
                        r_ack_ok <= ~w_data_lvl;
                    end
                end
                default: begin
                end
            endcase

            // Down-counter restarts on every device edge and on entry to RTS.
            if (w_clk_fe || w_inh_last) begin
                r_to_cnt <= TO_LOAD;
            end else if (w_to_active && (r_to_cnt != '0)) begin
                r_to_cnt <= r_to_cnt - 1'b1;
            end
        end
    end

    assign tx_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign ps2_clk_oe  = (r_state == INHIBIT);
    assign ps2_data_oe = w_inh_last || (r_state == RTS) ||
                         ((r_state == SEND) && r_data_oe);
    assign tx_done     = r_done;
    assign tx_err      = r_err;

endmodule
